// File: rtl/alu_issue_seq_pkg.sv
// Shared definitions for the ALU issue sequencer: ALU select codes,
// extended op codes and the sequencer state encoding.
package alu_issue_seq_pkg;

    // ALU function selects understood by the execution-stage ALU
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_MUL = 4'd2;
    localparam logic [3:0] ALU_DIV = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd4;
    localparam logic [3:0] ALU_OR  = 4'd5;
    localparam logic [3:0] ALU_XOR = 4'd6;
    localparam logic [3:0] ALU_GE  = 4'd7;
    localparam logic [3:0] ALU_LT  = 4'd8;
    localparam logic [3:0] ALU_EQ  = 4'd9;
    localparam logic [3:0] ALU_NE  = 4'd10;

    // Ops handled by the iterative divide loop rather than a single ALU pass
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_DCMP = 3'd2,
        ST_DSUB = 3'd3,
        ST_DZRO = 3'd4,
        ST_RESP = 3'd5
    } state_t;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_issue_seq_if.sv
// Request/response handshake bundle between issue logic and the sequencer.
// master = producer/consumer of operations, slave = the sequencer.
interface alu_issue_seq_if #(
    parameter int N = 64
) ();
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic         resp_valid;
    logic         resp_ready;
    logic [N-1:0] resp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/alu_issue_seq_div_step.sv
// Restoring-division datapath for one quotient bit per DCMP/DSUB pair.
// Holds the partial remainder, shifting quotient and bit counter; the
// compare and subtract themselves are done by the external ALU.
module alu_issue_seq_div_step #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [N-1:0] dividend,
    input  logic         cmp_en,
    input  logic         sub_en,
    input  logic [N-1:0] alu_res,
    output logic [N-1:0] cand,
    output logic [N-1:0] t_q,
    output logic [N-1:0] rem_next,
    output logic [N-1:0] quo_next,
    output logic         last
);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  rem_reg;
    logic [N-1:0]  quo_reg;
    logic [N-1:0]  t_reg;
    logic          ge_reg;
    logic [CW-1:0] cnt_reg;

    // Candidate remainder: shift the next dividend bit in from the quotient MSB
    assign cand = {rem_reg[N-2:0], quo_reg[N-1]};
    assign t_q  = t_reg;

    // Remainder restores to the candidate when the subtract was not allowed
    assign rem_next = ge_reg ? alu_res : t_reg;

    // Quotient shifts left one place, taking the compare outcome as new LSB
    assign quo_next[0] = ge_reg;
    generate
        for (genvar gi = 1; gi < N; gi++) begin : g_quo_shift
            assign quo_next[gi] = quo_reg[gi-1];
        end
    endgenerate

    // This subtract produces the final bit when only one iteration remains
    assign last = (cnt_reg == CW'(1));

    // Loop state: load on accept, capture compare, commit subtract
    always_ff @(posedge clk) begin
        if (srst) begin
            rem_reg <= '0;
            quo_reg <= '0;
            t_reg   <= '0;
            ge_reg  <= 1'b0;
            cnt_reg <= '0;
        end else if (load) begin
            rem_reg <= '0;
            quo_reg <= dividend;
            cnt_reg <= CW'(N);
        end else if (cmp_en) begin
            t_reg  <= cand;
            ge_reg <= alu_res[0];
        end else if (sub_en) begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            cnt_reg <= cnt_reg - CW'(1);
        end
    end

endmodule

// File: rtl/alu_issue_seq.sv
// ALU issue sequencer: accepts ops over valid/ready, drives the external
// combinational ALU from registered operands, and returns the result over
// a valid/ready response channel. Ops 11/12 (DIVU/REMU) run a restoring
// divide loop built from the ALU's >= and subtract functions.
// Optional macro ALU_ISSUE_DIV0_FAST_EN: divide/remainder by zero bypasses
// the loop and responds two edges after accept.
module alu_issue_seq
    import alu_issue_seq_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst,
    alu_issue_seq_if.slave bus,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_sel,
    input  logic [N-1:0] alu_res
);
`ifdef ALU_ISSUE_DIV0_FAST_EN
    localparam bit DIV0_FAST = 1'b1;
`else
    localparam bit DIV0_FAST = 1'b0;
`endif

    state_t       state_reg;
    logic [3:0]   op_reg;
    logic [N-1:0] a_reg;
    logic [N-1:0] b_reg;
    logic         resp_valid_reg;
    logic [N-1:0] resp_data_reg;

    logic         accept;
    logic         div_load;
    logic [N-1:0] div_cand;
    logic [N-1:0] div_t;
    logic [N-1:0] div_rem_next;
    logic [N-1:0] div_quo_next;
    logic         div_last;

    assign bus.req_ready  = (state_reg == ST_IDLE) && !rst;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_data  = resp_data_reg;

    assign accept   = bus.req_valid && bus.req_ready;
    assign div_load = accept && is_div_op(bus.req_op);

    alu_issue_seq_div_step #(.N(N)) u_div_step (
        .clk      (clk),
        .srst     (rst),
        .load     (div_load),
        .dividend (bus.req_a),
        .cmp_en   (state_reg == ST_DCMP),
        .sub_en   (state_reg == ST_DSUB),
        .alu_res  (alu_res),
        .cand     (div_cand),
        .t_q      (div_t),
        .rem_next (div_rem_next),
        .quo_next (div_quo_next),
        .last     (div_last)
    );

    // ALU operand/select drive decoded from the current state; idle is all zero
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = ALU_ADD;
        case (state_reg)
            ST_EXEC: begin
                alu_a   = a_reg;
                alu_b   = b_reg;
                alu_sel = op_reg;
            end
            ST_DCMP: begin
                alu_a   = div_cand;
                alu_b   = b_reg;
                alu_sel = ALU_GE;
            end
            ST_DSUB: begin
                alu_a   = div_t;
                alu_b   = b_reg;
                alu_sel = ALU_SUB;
            end
            default: begin
                alu_a   = '0;
                alu_b   = '0;
                alu_sel = ALU_ADD;
            end
        endcase
    end

    // Sequencer FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            op_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg <= bus.req_op;
                        a_reg  <= bus.req_a;
                        b_reg  <= bus.req_b;
                        if (is_div_op(bus.req_op)) begin
                            if (DIV0_FAST && (bus.req_b == '0)) begin
                                state_reg <= ST_DZRO;
                            end else begin
                                state_reg <= ST_DCMP;
                            end
                        end else begin
                            state_reg <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    resp_data_reg  <= alu_res;
                    resp_valid_reg <= 1'b1;
                    state_reg      <= ST_RESP;
                end
                ST_DCMP: begin
                    state_reg <= ST_DSUB;
                end
                ST_DSUB: begin
                    if (div_last) begin
                        resp_data_reg  <= (op_reg == OP_DIVU) ? div_quo_next : div_rem_next;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= ST_RESP;
                    end else begin
                        state_reg <= ST_DCMP;
                    end
                end
                ST_DZRO: begin
                    resp_data_reg  <= (op_reg == OP_DIVU) ? '1 : a_reg;
                    resp_valid_reg <= 1'b1;
                    state_reg      <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    resp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Scoreboard bench for alu_issue_seq: a behavioural ALU closes the loop,
// directed ops push expected data/latency, a negedge monitor compares.
module tb_alu_issue_seq;
    localparam int N = 64;
    localparam int EXEC_LAT = 2;
    localparam int DIV_LAT  = 2 * N + 1;
`ifdef ALU_ISSUE_DIV0_FAST_EN
    localparam int DZ_LAT = 2;
`else
    localparam int DZ_LAT = 2 * N + 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_sel;
    logic [N-1:0] alu_res;

    alu_issue_seq_if #(.N(N)) bus ();

    alu_issue_seq #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_sel (alu_sel),
        .alu_res (alu_res)
    );

    always #5 clk = ~clk;

    // Behavioural model of the execution-stage ALU
    always_comb begin
        alu_res = '0;
        case (alu_sel)
            4'd0:  alu_res = alu_a + alu_b;
            4'd1:  alu_res = alu_a - alu_b;
            4'd2:  alu_res = alu_a * alu_b;
            4'd3:  alu_res = (alu_b == '0) ? '1 : alu_a / alu_b;
            4'd4:  alu_res = alu_a & alu_b;
            4'd5:  alu_res = alu_a | alu_b;
            4'd6:  alu_res = alu_a ^ alu_b;
            4'd7:  alu_res = {{(N-1){1'b0}}, alu_a >= alu_b};
            4'd8:  alu_res = {{(N-1){1'b0}}, alu_a < alu_b};
            4'd9:  alu_res = {{(N-1){1'b0}}, alu_a == alu_b};
            4'd10: alu_res = {{(N-1){1'b0}}, alu_a != alu_b};
            default: alu_res = '0;
        endcase
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [N-1:0] exp_data_q[$];
    int           exp_lat_q[$];
    string        exp_name_q[$];
    int           acc_q[$];
    logic         prev_rv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: record accept edges, compare each rising response against the scoreboard
    always @(negedge clk) begin
        if (!rst && bus.req_valid && bus.req_ready) acc_q.push_back(cyc + 1);
        if (bus.resp_valid && !prev_rv) begin
            if (exp_data_q.size() == 0 || acc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got 0x%0h expected no response", bus.resp_data);
            end else begin
                automatic logic [N-1:0] ed = exp_data_q.pop_front();
                automatic int el = exp_lat_q.pop_front();
                automatic string en = exp_name_q.pop_front();
                automatic int acc = acc_q.pop_front();
                check({en, "_data"}, bus.resp_data, ed);
                check({en, "_lat"}, N'(cyc - acc + 1), N'(el));
            end
        end
        prev_rv = bus.resp_valid;
    end

    // Present a request (from posedge+1) and hold it until accepted
    task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp, input int lat, input string name);
        int w;
        exp_data_q.push_back(exp);
        exp_lat_q.push_back(lat);
        exp_name_q.push_back(name);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        w = 0;
        @(negedge clk);
        while (!bus.req_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (w >= 400) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: got req_ready=0 expected 1 within 400 cycles", name);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Wait (bounded) until resp_valid is seen high at a negedge
    task automatic wait_valid(input string name);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.resp_valid && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (w >= 400) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got resp_valid=0 expected 1 within 400 cycles", name);
        end
    endtask

    // Wait for a response and let the handshake (resp_ready=1) complete
    task automatic wait_resp(input string name);
        wait_valid(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", N'(bus.req_ready), N'(0));
        check("rst_resp_valid", N'(bus.resp_valid), N'(0));
        check("rst_resp_data", bus.resp_data, '0);
        check("rst_alu_sel", N'(alu_sel), N'(0));
        check("rst_alu_a", alu_a, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ADD with EXEC-phase ALU drive observed
        issue(4'd0, 64'd5, 64'd7, 64'd12, EXEC_LAT, "add");
        check("add_exec_sel", N'(alu_sel), N'(0));
        check("add_exec_a", alu_a, 64'd5);
        check("add_exec_b", alu_b, 64'd7);
        wait_resp("add");

        issue(4'd11, 64'd100, 64'd7, 64'd14, DIV_LAT, "divu_100_7");
        wait_resp("divu_100_7");
        issue(4'd12, 64'd100, 64'd7, 64'd2, DIV_LAT, "remu_100_7");
        wait_resp("remu_100_7");
        issue(4'd11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, DIV_LAT, "divu_max_1");
        wait_resp("divu_max_1");
        issue(4'd11, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, DZ_LAT, "divu_by0");
        wait_resp("divu_by0");
        issue(4'd12, 64'h1234, 64'd0, 64'h1234, DZ_LAT, "remu_by0");
        wait_resp("remu_by0");
        issue(4'd14, 64'd1, 64'd2, 64'd0, EXEC_LAT, "reserved14");
        wait_resp("reserved14");

        // Backpressure: response must hold while resp_ready is low
        bus.resp_ready = 1'b0;
        issue(4'd0, 64'd1, 64'd2, 64'd3, EXEC_LAT, "bp_add");
        wait_valid("bp_add");
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_data", bus.resp_data, 64'd3);
            check("bp_hold_valid", N'(bus.resp_valid), N'(1));
            check("bp_req_ready", N'(bus.req_ready), N'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        issue(4'd1, 64'd9, 64'd4, 64'd5, EXEC_LAT, "sub_9_4");
        wait_resp("sub_9_4");

        // Reset in the compare phase of bit 10 discards the divide
        issue(4'd11, 64'd1000, 64'd3, 64'd333, DIV_LAT, "div_discard");
        repeat (20) @(posedge clk);
        #1;
        check("mid_dcmp_sel", N'(alu_sel), N'(7));
        rst = 1'b1;
        exp_data_q.delete();
        exp_lat_q.delete();
        exp_name_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_resp_valid", N'(bus.resp_valid), N'(0));
        check("post_rst_req_ready", N'(bus.req_ready), N'(1));
        check("post_rst_alu_sel", N'(alu_sel), N'(0));

        issue(4'd9, 64'd3, 64'd3, 64'd1, EXEC_LAT, "eq_3_3");
        wait_resp("eq_3_3");

        repeat (3) @(posedge clk);
        check("sb_drained", N'(exp_data_q.size()), N'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Initiator side of the ALU operand/select interface. Accepts operation requests over a valid/ready handshake and drives the combinational ALU's A, B and sel inputs from registered operands.
- Captures the ALU result and returns it over a valid/ready response channel.
- Adds unsigned divide and remainder ops, implemented as an iterative restoring loop that uses only the ALU's subtract and >= functions.
- Sits between decode/issue and the execution-stage ALU in the npc core.

Parameters:
N, 64, datapath width of operands, ALU ports and result

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_op  input  4  0-10 = ALU sel passthrough, 11 = DIVU iterative, 12 = REMU iterative, 13-15 = reserved
req_a  input  N  operand A / dividend
req_b  input  N  operand B / divisor
resp_valid  output  1  result available
resp_ready  input  1  consumer takes result
resp_data  output  N  result
alu_a  output  N  ALU operand A
alu_b  output  N  ALU operand B
alu_sel  output  4  ALU function select
alu_res  input  N  ALU result (combinational from alu_a/alu_b/alu_sel)

Behaviour:
- Clocking/reset: one clock clk; reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: state IDLE, resp_valid 0, resp_data 0, alu_a 0, alu_b 0, alu_sel 0. req_ready is 0 while rst is high.
- States:
  - IDLE: req_ready=1, ALU outputs 0.
  - EXEC: single ALU op.
  - DCMP / DSUB: divide loop.
  - RESP: response held.
- Accept: on an edge with req_valid && req_ready, latch op/a/b.
  - op 0-10 and 13-15 -> EXEC.
  - op 11/12 -> DCMP, with rem=0, quo=dividend, cnt=N.
- EXEC:
  - Drive alu_a=a, alu_b=b, alu_sel=op. Reserved ops drive sel=op and the ALU yields 0.
  - At the edge: resp_data<=alu_res, go to RESP.
  - resp_valid rises on the 2nd edge after the accepting edge.
- Divide loop, per bit:
  - DCMP: candidate t={rem[N-2:0],quo[N-1]}. Drive alu_a=t, alu_b=divisor, alu_sel=7 (>=). At the edge: latch ge=alu_res[0], latch t, go to DSUB.
  - DSUB: drive alu_a=t, alu_b=divisor, alu_sel=1 (subtract).
    - At the edge: rem<= ge ? alu_res : t; quo<={quo[N-2:0],ge}; cnt--.
    - cnt reaching 0 -> resp_data<= (op==11 ? quo : rem), go to RESP. Otherwise -> DCMP.
  - Latency: resp_valid rises 2N+1 edges after accept (129 for N=64). Fixed regardless of operand values.
  - Divisor 0 falls out of the algorithm naturally: quotient all ones, remainder = dividend.
- RESP:
  - resp_valid=1; resp_data stable; req_ready=0.
  - On an edge with resp_ready: resp_valid<=0, go to IDLE.
  - Next request is accepted no earlier than the following cycle (no same-cycle turnaround).
- req_ready is never 1 outside IDLE. Requests presented while busy are held by the producer, not dropped.
- Reset mid-operation: on the next edge, the in-flight op is discarded, resp_valid=0, state IDLE.
- Width rules: all arithmetic is N-bit unsigned via the ALU. Compare results use alu_res[0] only.

Optional Feature:
- Macro: ALU_ISSUE_DIV0_FAST_EN.
- Defined: op 11/12 with req_b==0 skips the loop. Response of all ones (DIVU) or the dividend (REMU) is valid 2 edges after accept. The ALU is driven with sel 0 in the intervening cycle.
- Undefined: divide by zero runs the full 2N-cycle loop with identical results.

Decomposition:
- Shared package (alu_pkg):
  - sel localparams: ALU_ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5, XOR=6, GE=7, LT=8, EQ=9, NE=10.
  - Op codes OP_DIVU=11, OP_REMU=12.
  - FSM state encoding.
- Sub-module alu_div_step (natural, optional): holds rem/quo/cnt registers and the shift/select logic for one bit. The FSM stays in alu_issue_seq.
- The ALU itself stays outside this block.

Test Plan:
- ADD: op=0, a=5, b=7 -> resp_data=12, resp_valid on 2nd edge after accept; alu_sel=0 observed during EXEC.
- DIVU/REMU: op=11, a=100, b=7 -> 14; op=12 same operands -> 2; each responds exactly 129 edges after accept. Also a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> quotient = a.
- Divide by zero: op=11, a=0x1234, b=0 -> 0xFFFF_FFFF_FFFF_FFFF; op=12 -> 0x1234. Latency 129 without ALU_ISSUE_DIV0_FAST_EN, 2 with it.
- Backpressure: ADD 1+2 with resp_ready low 5 cycles -> resp_data=3 stable, req_ready=0 throughout; after resp_ready=1, the next request (SUB 9-4) returns 5.
- Reset mid-divide: assert rst at DCMP of bit 10 -> resp_valid 0, req_ready 1 the cycle after rst drops; subsequent EQ 3,3 -> 1.
- Reserved op=14, a=1, b=2 -> resp_data=0 with EXEC latency.
